booth_accumulator: RTL and testbench

BOOTH_ACCUMULATOR -- requirements
Module: booth_accumulator

---
 rtl/booth_accumulator_pkg.sv | 13 +
 rtl/csa_3to2_64bit.sv | 20 ++
 rtl/booth_accumulator.sv | 90 +++++++++
 tb/tb_booth_accumulator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/booth_accumulator_pkg.sv
// Shared definitions for the Booth multiplier datapath: FSM state encoding
// and the default number of partial-product beats per multiply.
package booth_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int BEATS_DEFAULT = 8;

endpackage

// File: rtl/csa_3to2_64bit.sv
// 3:2 carry-save compressor: reduces three operands to a sum word and a
// carry word, with the carry word already shifted into its weight position.
module csa_3to2_64bit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Carry
);

  logic [WIDTH-1:0] majority;

  assign Sum      = X ^ Y ^ Z;
  assign majority = (X & Y) | (X & Z) | (Y & Z);
  // The top carry-out falls off the end, giving modulo 2^WIDTH behaviour.
  assign Carry    = {majority[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/booth_accumulator.sv
// Accumulates BEATS beats of three pre-shifted Booth partial products into a
// registered WIDTH-bit product, with a simple IDLE/ACCUM/DONE handshake.
module booth_accumulator
  import booth_accumulator_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BEATS = BEATS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pp_valid,
  input  logic [WIDTH-1:0]   BoothA,
  input  logic [WIDTH-1:0]   BoothB,
  input  logic [WIDTH-1:0]   BoothC,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Product,
  output logic [WIDTH/2-1:0] Hi,
  output logic [WIDTH/2-1:0] Lo
);

  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] beat_cnt;
  logic [WIDTH-1:0] pp_sum;
  logic [WIDTH-1:0] pp_carry;
  logic [WIDTH-1:0] acc_next;
  logic             accept;
  logic             restart;

  csa_3to2_64bit #(
    .WIDTH(WIDTH)
  ) u_csa (
    .X    (BoothA),
    .Y    (BoothB),
    .Z    (BoothC),
    .Sum  (pp_sum),
    .Carry(pp_carry)
  );

  // The compressed beat folds into the accumulator through one carry-propagate adder.
  assign acc_next = acc + pp_sum + pp_carry;

  assign accept  = (state == ACCUM) && pp_valid;
  assign restart = ((state == IDLE) || (state == DONE)) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (pp_valid && (beat_cnt == LAST_BEAT)) next_state = DONE;
      DONE:    if (start) next_state = ACCUM;
      default: next_state = IDLE;
    endcase
  end

  // Start and pp_valid are only honoured in their own states, so stray pulses are harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      beat_cnt <= '0;
    end else if (restart) begin
      acc      <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      acc      <= acc_next;
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  assign busy    = (state == ACCUM);
  assign done    = (state == DONE);
  assign Product = acc;
  assign Hi      = acc[WIDTH-1:WIDTH/2];
  assign Lo      = acc[WIDTH/2-1:0];

endmodule

// File: tb/tb_booth_accumulator.sv
// Scoreboard bench for booth_accumulator: directed multiplies push their
// hand-computed product; a monitor pops and compares on each rising done.
module tb_booth_accumulator;
  import booth_accumulator_pkg::*;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             pp_valid;
  logic [WIDTH-1:0] BoothA;
  logic [WIDTH-1:0] BoothB;
  logic [WIDTH-1:0] BoothC;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Product;
  logic [WIDTH/2-1:0] Hi;
  logic [WIDTH/2-1:0] Lo;

  int checks = 0;
  int passed = 0;
  logic [WIDTH-1:0] expq[$];
  logic [WIDTH-1:0] exp_val;
  logic done_q = 1'b0;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  booth_accumulator #(
    .WIDTH(WIDTH),
    .BEATS(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pp_valid(pp_valid),
    .BoothA  (BoothA),
    .BoothB  (BoothB),
    .BoothC  (BoothC),
    .busy    (busy),
    .done    (done),
    .Product (Product),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drive one cycle of inputs just after the rising edge, then release the pulses.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] c, input logic v, input logic s);
    BoothA   = a;
    BoothB   = b;
    BoothC   = c;
    pp_valid = v;
    start    = s;
    @(posedge clk);
    #1;
    pp_valid = 1'b0;
    start    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (expq.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_done: done rose with no result queued, product %h", Product);
      end else begin
        exp_val = expq.pop_front();
        checkOutput("sb_product", Product, exp_val);
        checkOutput("sb_hi", {32'h0, Hi}, {32'h0, exp_val[63:32]});
        checkOutput("sb_lo", {32'h0, Lo}, {32'h0, exp_val[31:0]});
        checkOutput("sb_busy_low", {63'h0, busy}, 64'h0);
      end
    end
    done_q = done;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pp_valid = 1'b0;
    BoothA = '0; BoothB = '0; BoothC = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_product", Product, 64'h0);
    checkOutput("reset_busy", {63'h0, busy}, 64'h0);
    checkOutput("reset_done", {63'h0, done}, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_busy", {63'h0, busy}, 64'h0);

    // Basic accumulation: 8 x (1+2+4) = 0x38.
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    checkOutput("basic_busy_after_start", {63'h0, busy}, 64'h1);
    for (int i = 0; i < 7; i++) applyStimulus(64'd1, 64'd2, 64'd4, 1'b1, 1'b0);
    checkOutput("basic_partial", Product, 64'h31);
    checkOutput("basic_not_done_7", {63'h0, done}, 64'h0);
    expq.push_back(64'h38);
    applyStimulus(64'd1, 64'd2, 64'd4, 1'b1, 1'b0);
    checkOutput("basic_done_after_8", {63'h0, done}, 64'h1);

    // Back-to-back start straight out of DONE, then negative operands.
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    checkOutput("b2b_done_low", {63'h0, done}, 64'h0);
    checkOutput("b2b_busy_high", {63'h0, busy}, 64'h1);
    checkOutput("b2b_product_clear", Product, 64'h0);
    for (int i = 0; i < 7; i++) applyStimulus(ONES, '0, '0, 1'b1, 1'b0);
    expq.push_back(64'hFFFFFFFFFFFFFFF8);
    applyStimulus(ONES, '0, '0, 1'b1, 1'b0);
    repeat (3) applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkOutput("neg_hold_product", Product, 64'hFFFFFFFFFFFFFFF8);
    checkOutput("neg_hold_hi", {32'h0, Hi}, 64'hFFFFFFFF);
    checkOutput("neg_hold_lo", {32'h0, Lo}, 64'hFFFFFFF8);
    checkOutput("neg_hold_done", {63'h0, done}, 64'h1);

    // Stall and wrap: all-ones + 1 wraps to zero, gaps between every beat.
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    applyStimulus(ONES, 64'd1, '0, 1'b1, 1'b0);
    checkOutput("wrap_first_beat", Product, 64'h0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(64'h5A5A, 64'h1234, 64'h77, 1'b0, 1'b0);
      checkOutput("stall_hold_busy", {63'h0, busy}, 64'h1);
      if (i == 7) expq.push_back(64'h0);
      applyStimulus('0, '0, '0, 1'b1, 1'b0);
    end
    checkOutput("stall_done_after_8", {63'h0, done}, 64'h1);

    // Reset mid-operation after three beats, then ignored-event run.
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(64'd1, 64'd2, 64'd4, 1'b1, 1'b0);
    checkOutput("midop_partial", Product, 64'h15);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_product", Product, 64'h0);
    checkOutput("async_reset_hi", {32'h0, Hi}, 64'h0);
    checkOutput("async_reset_busy", {63'h0, busy}, 64'h0);
    checkOutput("async_reset_done", {63'h0, done}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(64'd1, 64'd2, 64'd4, 1'b1, 1'b0);
    checkOutput("idle_ignores_pp_busy", {63'h0, busy}, 64'h0);
    checkOutput("idle_ignores_pp_product", Product, 64'h0);
    applyStimulus(64'd1, 64'd2, 64'd4, 1'b1, 1'b1);
    checkOutput("start_cycle_pp_ignored", Product, 64'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expq.push_back(64'h38);
      applyStimulus(64'd1, 64'd2, 64'd4, 1'b1, (i == 3));
    end
    checkOutput("ignored_done", {63'h0, done}, 64'h1);
    applyStimulus(64'd8, 64'd8, 64'd8, 1'b1, 1'b0);
    checkOutput("done_ignores_pp", Product, 64'h38);
    checkOutput("done_ignores_pp_state", {63'h0, done}, 64'h1);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (expq.size() == 0) passed++;
    else $display("[TB] FAIL scoreboard_drain: %0d results never presented, expected 0", expq.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
